// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder: single-outstanding instruction fetch port with
// fixed wait states and a side load port into the instruction store.
module instr_fetch_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Req_Valid,
  input  logic [31:0] Req_Addr,
  output logic        Req_Ready,
  output logic        Resp_Valid,
  input  logic        Resp_Ready,
  output logic [31:0] Resp_Instr,
  output logic        Resp_Error,
  input  logic        Load_En,
  input  logic [31:0] Load_Addr,
  input  logic [31:0] Load_Data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_INIT =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic [31:0]   addr_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          capture;
  logic [31:0]   cap_addr;
  logic          cap_err;
  logic [AW-1:0] cap_idx;
  logic [AW-1:0] load_idx;
  logic          unused_load_bits;

  assign Req_Ready  = (state == IDLE);
  assign Resp_Valid = (state == RESP);
  assign accept     = Req_Valid && Req_Ready;

  // With zero wait states the capture edge is the accept edge, so the
  // address must come straight from the request port.
  assign cap_addr = (state == IDLE) ? Req_Addr : addr_q;
  assign cap_err  = (cap_addr[1:0] != 2'b00) ||
                    ((cap_addr >> (AW + 2)) != 32'd0);
  assign cap_idx  = cap_addr[AW+1:2];
  assign load_idx = Load_Addr[AW+1:2];

  assign unused_load_bits = ^{Load_Addr[31:AW+2], Load_Addr[1:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nxt = RESP;
            capture   = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WS_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (Resp_Ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= 32'd0;
      Resp_Instr <= 32'd0;
      Resp_Error <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q <= Req_Addr;
      end
      if (capture) begin
        Resp_Error <= cap_err;
        Resp_Instr <= cap_err ? NOP_INSTR : mem[cap_idx];
      end
    end
  end

  // Store has no reset; a same-edge load lands after the capture read.
  always_ff @(posedge CLK) begin
    if (Load_En) begin
      mem[load_idx] <= Load_Data;
    end
  end

endmodule
